// File: rtl/lcd_ctrl_pkg.sv
// Shared definitions for the LCD image controller: 4-bit command codes and the
// frame-level FSM state encoding.
package lcd_ctrl_pkg;

    localparam logic [3:0] CMD_WRITE  = 4'd0;
    localparam logic [3:0] CMD_UP     = 4'd1;
    localparam logic [3:0] CMD_DOWN   = 4'd2;
    localparam logic [3:0] CMD_LEFT   = 4'd3;
    localparam logic [3:0] CMD_RIGHT  = 4'd4;
    localparam logic [3:0] CMD_MAX    = 4'd5;
    localparam logic [3:0] CMD_MIN    = 4'd6;
    localparam logic [3:0] CMD_AVG    = 4'd7;
    localparam logic [3:0] CMD_CCW    = 4'd8;
    localparam logic [3:0] CMD_CW     = 4'd9;
    localparam logic [3:0] CMD_MIRX   = 4'd10;
    localparam logic [3:0] CMD_MIRY   = 4'd11;
    localparam logic [3:0] CMD_ORIGIN = 4'd12;
    localparam logic [3:0] CMD_MEDIAN = 4'd13;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_OPER  = 3'd2,
        ST_STORE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/lcd_win_alu.sv
// Combinational 2x2 window operator. cmd 13 becomes MEDIAN only when
// LCD_CTRL_MEDIAN_EN is defined; otherwise it is a no-op with no sort logic.
module lcd_win_alu
    import lcd_ctrl_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        cmd,
    input  logic [DATA_W-1:0] tl,
    input  logic [DATA_W-1:0] tr,
    input  logic [DATA_W-1:0] bl,
    input  logic [DATA_W-1:0] br,
    output logic [DATA_W-1:0] tl_n,
    output logic [DATA_W-1:0] tr_n,
    output logic [DATA_W-1:0] bl_n,
    output logic [DATA_W-1:0] br_n,
    output logic              we
);

    function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [DATA_W-1:0] min2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    logic [DATA_W+1:0] sum_s;
    logic [DATA_W-1:0] max_s;
    logic [DATA_W-1:0] min_s;
    logic [DATA_W-1:0] avg_s;

    assign sum_s = {2'b00, tl} + {2'b00, tr} + {2'b00, bl} + {2'b00, br};
    assign avg_s = DATA_W'(sum_s >> 2);
    assign max_s = max2(max2(tl, tr), max2(bl, br));
    assign min_s = min2(min2(tl, tr), min2(bl, br));

`ifdef LCD_CTRL_MEDIAN_EN
    // Pairwise sort network: the middle two of four are max(lows) and min(highs).
    logic [DATA_W-1:0] mid_lo_s;
    logic [DATA_W-1:0] mid_hi_s;
    logic [DATA_W:0]   mid_sum_s;
    logic [DATA_W-1:0] median_s;

    assign mid_lo_s  = max2(min2(tl, tr), min2(bl, br));
    assign mid_hi_s  = min2(max2(tl, tr), max2(bl, br));
    assign mid_sum_s = {1'b0, mid_lo_s} + {1'b0, mid_hi_s};
    assign median_s  = DATA_W'(mid_sum_s >> 1);
`endif

    // Select the new window contents for the current command.
    always_comb begin
        tl_n = tl;
        tr_n = tr;
        bl_n = bl;
        br_n = br;
        we   = 1'b0;
        case (cmd)
            CMD_MAX:  begin tl_n = max_s; tr_n = max_s; bl_n = max_s; br_n = max_s; we = 1'b1; end
            CMD_MIN:  begin tl_n = min_s; tr_n = min_s; bl_n = min_s; br_n = min_s; we = 1'b1; end
            CMD_AVG:  begin tl_n = avg_s; tr_n = avg_s; bl_n = avg_s; br_n = avg_s; we = 1'b1; end
            CMD_CCW:  begin tl_n = tr; tr_n = br; br_n = bl; bl_n = tl; we = 1'b1; end
            CMD_CW:   begin tl_n = bl; tr_n = tl; br_n = tr; bl_n = br; we = 1'b1; end
            CMD_MIRX: begin tl_n = bl; bl_n = tl; tr_n = br; br_n = tr; we = 1'b1; end
            CMD_MIRY: begin tl_n = tr; tr_n = tl; bl_n = br; br_n = bl; we = 1'b1; end
`ifdef LCD_CTRL_MEDIAN_EN
            CMD_MEDIAN: begin
                tl_n = median_s; tr_n = median_s; bl_n = median_s; br_n = median_s; we = 1'b1;
            end
`endif
            default:  begin tl_n = tl; tr_n = tr; bl_n = bl; br_n = br; we = 1'b0; end
        endcase
    end

endmodule

// File: rtl/lcd_ctrl_gen.sv
// Parametrised LCD image controller: loads IROM into a buffer, applies 2x2 window
// commands, stores to IRAM. Optional MEDIAN command via LCD_CTRL_MEDIAN_EN.
module lcd_ctrl_gen
    import lcd_ctrl_pkg::*;
#(
    parameter int  IMG_W  = 8,
    parameter int  IMG_H  = 8,
    parameter int  DATA_W = 8,
    localparam int AW     = $clog2(IMG_W * IMG_H)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        cmd,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    output logic              IROM_rd,
    output logic [AW-1:0]     IROM_A,
    input  logic [DATA_W-1:0] IROM_Q,
    output logic              IRAM_valid,
    output logic [AW-1:0]     IRAM_A,
    output logic [DATA_W-1:0] IRAM_D,
    output logic              busy,
    output logic              done
);

    localparam int N = IMG_W * IMG_H;
    localparam logic [AW:0]     CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]     CNT_N    = (AW+1)'(N);
    localparam logic [AW:0]     CNT_LAST = (AW+1)'(N - 1);
    localparam logic [AW-1:0]   A_ZERO   = AW'(0);
    localparam logic [AW-1:0]   ONE_A    = AW'(1);
    localparam logic [AW-1:0]   X_MAX    = AW'(IMG_W - 1);
    localparam logic [AW-1:0]   Y_MAX    = AW'(IMG_H - 1);
    localparam logic [AW-1:0]   X_C      = AW'(IMG_W / 2);
    localparam logic [AW-1:0]   Y_C      = AW'(IMG_H / 2);
    localparam logic [DATA_W-1:0] D_ZERO = DATA_W'(0);

    function automatic logic [AW-1:0] pix_addr(input logic [AW-1:0] px, input logic [AW-1:0] py);
        return AW'(px + py * IMG_W);
    endfunction

    state_e            state_r, state_s;
    logic [AW:0]       cnt_r, cnt_s;
    logic [AW-1:0]     x_r, y_r, x_s, y_s;
    logic [DATA_W-1:0] mem_r [N];
    logic              cmd_ready_r, rom_rd_r, ram_valid_r, busy_r, done_r;
    logic [AW-1:0]     rom_a_r, ram_a_r;
    logic [DATA_W-1:0] ram_d_r;

    logic              accept_s, alu_we_s;
    logic [AW-1:0]     tl_a_s, tr_a_s, bl_a_s, br_a_s;
    logic [DATA_W-1:0] tl_s, tr_s, bl_s, br_s;
    logic [DATA_W-1:0] tl_n_s, tr_n_s, bl_n_s, br_n_s;

    assign accept_s = cmd_valid && cmd_ready_r;
    assign tl_a_s   = pix_addr(x_r - ONE_A, y_r - ONE_A);
    assign tr_a_s   = pix_addr(x_r,         y_r - ONE_A);
    assign bl_a_s   = pix_addr(x_r - ONE_A, y_r);
    assign br_a_s   = pix_addr(x_r,         y_r);
    assign tl_s     = mem_r[tl_a_s];
    assign tr_s     = mem_r[tr_a_s];
    assign bl_s     = mem_r[bl_a_s];
    assign br_s     = mem_r[br_a_s];

    lcd_win_alu #(.DATA_W(DATA_W)) u_alu (
        .cmd  (cmd),
        .tl   (tl_s),
        .tr   (tr_s),
        .bl   (bl_s),
        .br   (br_s),
        .tl_n (tl_n_s),
        .tr_n (tr_n_s),
        .bl_n (bl_n_s),
        .br_n (br_n_s),
        .we   (alu_we_s)
    );

    // Next-state, sequence counter and op-point movement.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        x_s     = x_r;
        y_s     = y_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_LOAD;
                    cnt_s   = CNT_ZERO;
                    x_s     = X_C;
                    y_s     = Y_C;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // One extra cycle after the last address lets its ROM data land.
                if (cnt_r == CNT_N) begin
                    state_s = ST_OPER;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_OPER: begin
                if (accept_s) begin
                    case (cmd)
                        CMD_WRITE:  begin state_s = ST_STORE; cnt_s = CNT_ZERO; end
                        CMD_UP:     y_s = (y_r > ONE_A) ? y_r - ONE_A : y_r;
                        CMD_DOWN:   y_s = (y_r < Y_MAX) ? y_r + ONE_A : y_r;
                        CMD_LEFT:   x_s = (x_r > ONE_A) ? x_r - ONE_A : x_r;
                        CMD_RIGHT:  x_s = (x_r < X_MAX) ? x_r + ONE_A : x_r;
                        CMD_ORIGIN: begin x_s = X_C; y_s = Y_C; end
                        default:    begin x_s = x_r; y_s = y_r; end
                    endcase
                end else begin
                    state_s = ST_OPER;
                end
            end
            ST_STORE: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = ST_DONE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State registers plus outputs registered from the next-state decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            x_r         <= X_C;
            y_r         <= Y_C;
            cmd_ready_r <= 1'b0;
            rom_rd_r    <= 1'b0;
            rom_a_r     <= A_ZERO;
            ram_valid_r <= 1'b0;
            ram_a_r     <= A_ZERO;
            ram_d_r     <= D_ZERO;
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            x_r         <= x_s;
            y_r         <= y_s;
            cmd_ready_r <= (state_s == ST_OPER);
            rom_rd_r    <= (state_s == ST_LOAD) && (cnt_s != CNT_N);
            rom_a_r     <= ((state_s == ST_LOAD) && (cnt_s != CNT_N)) ? AW'(cnt_s) : A_ZERO;
            ram_valid_r <= (state_s == ST_STORE);
            ram_a_r     <= (state_s == ST_STORE) ? AW'(cnt_s) : A_ZERO;
            ram_d_r     <= (state_s == ST_STORE) ? mem_r[AW'(cnt_s)] : D_ZERO;
            busy_r      <= (state_s != ST_OPER);
            done_r      <= (state_s == ST_DONE);
        end
    end

    // Image buffer: ROM data trails its address by one cycle; window updates in OPER.
    always_ff @(posedge clk) begin
        if ((state_r == ST_LOAD) && (cnt_r != CNT_ZERO)) begin
            mem_r[AW'(cnt_r - CNT_ONE)] <= IROM_Q;
        end else if (accept_s && alu_we_s) begin
            mem_r[tl_a_s] <= tl_n_s;
            mem_r[tr_a_s] <= tr_n_s;
            mem_r[bl_a_s] <= bl_n_s;
            mem_r[br_a_s] <= br_n_s;
        end
    end

    assign cmd_ready  = cmd_ready_r;
    assign IROM_rd    = rom_rd_r;
    assign IROM_A     = rom_a_r;
    assign IRAM_valid = ram_valid_r;
    assign IRAM_A     = ram_a_r;
    assign IRAM_D     = ram_d_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule
